// File: rtl/rv32_m_arbiter.sv
// rv32_m_arbiter
// Shares one external RV32M multiply/divide unit between N_CORES execution
// stages. Each core posts a one-cycle request pulse with operands. The pulse
// is buffered per core, and the arbiter grants the unit round-robin. The
// granted request is replayed to the unit as a one-cycle enable. The unit's
// result comes back to the owning core with a one-cycle acknowledge.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-low reset
//   i_core_en[k]        request pulse from core k
//   i_core_rs1/rs2/f3   per-core operands, core k at [k*XLEN +: XLEN] / [k*3 +: 3]
//   o_core_ack[k]       one-cycle result-valid pulse to core k
//   o_core_res          result, valid while any o_core_ack bit is high
//   o_core_busy[k]      core k has a request pending or in service
//   o_m_en              one-cycle enable to the M unit
//   o_m_rs1/rs2/f3      operands to the M unit, held stable until i_m_ack
//   i_m_ack, i_m_res    M unit done strobe and result
module rv32_m_arbiter #(
  parameter int N_CORES = 2,
  parameter int XLEN    = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_CORES-1:0]      i_core_en,
  input  logic [N_CORES*XLEN-1:0] i_core_rs1,
  input  logic [N_CORES*XLEN-1:0] i_core_rs2,
  input  logic [N_CORES*3-1:0]    i_core_f3,
  output logic [N_CORES-1:0]      o_core_ack,
  output logic [XLEN-1:0]         o_core_res,
  output logic [N_CORES-1:0]      o_core_busy,
  output logic                    o_m_en,
  output logic [XLEN-1:0]         o_m_rs1,
  output logic [XLEN-1:0]         o_m_rs2,
  output logic [2:0]              o_m_f3,
  input  logic                    i_m_ack,
  input  logic [XLEN-1:0]         i_m_res
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      f3;
  } m_req_t;

  // ---------------------------------------------------------------------------
  // Per-core request buffers
  // ---------------------------------------------------------------------------
  m_req_t [N_CORES-1:0] core_req;
  m_req_t [N_CORES-1:0] buf_q, buf_d;
  logic   [N_CORES-1:0] pend_q, pend_d;
  logic   [N_CORES-1:0] ack_q, ack_d;

  for (genvar k = 0; k < N_CORES; k++) begin : g_core
    assign core_req[k] = {i_core_rs1[k*XLEN +: XLEN],
                          i_core_rs2[k*XLEN +: XLEN],
                          i_core_f3[k*3 +: 3]};
  end

  // A core's pending bit stays set through its own ack cycle. It clears on
  // the edge after the ack. A pulse coincident with the ack is dropped.
  always_comb begin
    pend_d = pend_q;
    buf_d  = buf_q;
    for (int k = 0; k < N_CORES; k++) begin
      if (pend_q[k]) begin
        if (ack_q[k]) pend_d[k] = 1'b0;
      end else if (i_core_en[k]) begin
        pend_d[k] = 1'b1;
        buf_d[k]  = core_req[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pend_q <= '0;
      buf_q  <= '0;
    end else begin
      pend_q <= pend_d;
      buf_q  <= buf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first pending index at or after rr_ptr, with wrap
  // ---------------------------------------------------------------------------
  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] sel;
  logic          sel_vld;
  logic [PW:0]   cand;

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_CORES; i++) begin
      cand = {1'b0, rr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_CORES)) cand = cand - (PW+1)'(N_CORES);
      if (!sel_vld && pend_q[cand[PW-1:0]]) begin
        sel_vld = 1'b1;
        sel     = cand[PW-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   g_q, g_d;
  m_req_t          mreq_q, mreq_d;
  logic [XLEN-1:0] res_q, res_d;

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    mreq_d  = mreq_q;
    res_d   = res_q;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        // Hold off while an ack is on the wire. The served core's pending
        // bit is still set in that cycle and must not be granted again.
        if (sel_vld && (ack_q == '0)) begin
          g_d     = sel;
          mreq_d  = buf_q[sel];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (i_m_ack) begin
          res_d      = i_m_res;
          ack_d[g_q] = 1'b1;
          rr_d       = (g_q == PW'(N_CORES-1)) ? '0 : g_q + PW'(1);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      rr_q    <= '0;
      mreq_q  <= '0;
      res_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      rr_q    <= rr_d;
      mreq_q  <= mreq_d;
      res_q   <= res_d;
      ack_q   <= ack_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_m_en      = (state_q == S_ISSUE);
  assign o_m_rs1     = mreq_q.rs1;
  assign o_m_rs2     = mreq_q.rs2;
  assign o_m_f3      = mreq_q.f3;
  assign o_core_ack  = ack_q;
  assign o_core_res  = res_q;
  assign o_core_busy = pend_q;

endmodule
